// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request from the PC and
// fills the IF/ID register. A one-word skid buffer keeps a returned word while the pipe is stalled.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_skid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    logic        w_in_req;
    logic        w_advance;
    logic        w_capture;
    logic        w_bubble;
    logic [31:0] w_word;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_advance = !stall && (w_in_req ? imem_ready : 1'b1);
    assign w_capture = w_in_req && imem_ready && stall;
    // Memory is late and nothing holds the pipe: push a bubble, retry the same PC.
    assign w_bubble  = w_in_req && !imem_ready && !stall;
    assign w_word    = w_in_req ? imem_rdata : r_skid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_REQ;
            r_pc       <= PC_RESET;
            r_skid     <= 32'h0000_0000;
            r_if_instr <= NOP_WORD;
            r_if_pc    <= PC_RESET;
            r_if_valid <= 1'b0;
        end else if (w_advance) begin
            r_state    <= ST_REQ;
            r_pc       <= npc;
            r_if_pc    <= r_pc;
            r_if_instr <= flush ? NOP_WORD : w_word;
            r_if_valid <= !flush;
        end else if (w_capture) begin
            r_state <= ST_HOLD;
            r_skid  <= imem_rdata;
        end else if (w_bubble) begin
            r_if_instr <= NOP_WORD;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b0;
        end
    end

    assign pc          = r_pc;
    assign imem_req    = w_in_req;
    assign imem_addr   = r_pc;
    assign fetch_busy  = w_in_req && !imem_ready;
    assign if_id_instr = r_if_instr;
    assign if_id_pc    = r_if_pc;
    assign if_id_valid = r_if_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes hand-computed post-edge expectations,
// a monitor pops and compares them one cycle at a time.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_busy;

    fetch_unit #(.PC_RESET(32'h0000_3000), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .npc(npc), .stall(stall), .flush(flush),
        .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .fetch_busy(fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        valid;
        logic        req;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic void chk_all(string tag, logic [31:0] e_pc, logic [31:0] e_instr,
                                    logic [31:0] e_ifpc, logic e_valid, logic e_req, logic e_busy);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imem_addr"}, imem_addr, e_pc);
        chk({tag, ".if_id_instr"}, if_id_instr, e_instr);
        chk({tag, ".if_id_pc"}, if_id_pc, e_ifpc);
        chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".fetch_busy"}, {31'd0, fetch_busy}, {31'd0, e_busy});
    endfunction

    // Monitor: compares one queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e.name, e.pc, e.instr, e.ifpc, e.valid, e.req, e.busy);
                $display("txn %-10s pc=%08h instr=%08h ifpc=%08h v=%0b req=%0b busy=%0b",
                         e.name, pc, if_id_instr, if_id_pc, if_id_valid, imem_req, fetch_busy);
            end
        end
    end

    task automatic step(string name, logic rdy, logic [31:0] rdata, logic stl, logic fl,
                        logic [31:0] n, logic [31:0] e_pc, logic [31:0] e_instr,
                        logic [31:0] e_ifpc, logic e_valid, logic e_req, logic e_busy);
        exp_t e;
        @(negedge clk);
        imem_ready = rdy;
        imem_rdata = rdata;
        stall      = stl;
        flush      = fl;
        npc        = n;
        e.name = name; e.pc = e_pc; e.instr = e_instr; e.ifpc = e_ifpc;
        e.valid = e_valid; e.req = e_req; e.busy = e_busy;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b0; npc = '0; stall = 1'b0; flush = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        #12;
        chk_all("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        //    name        rdy  rdata          stl   fl    npc            pc             instr          ifpc           v     req   busy
        step("zero_wait", 1'b1, 32'h2408_0005, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3004, 32'h2408_0005, 32'h0000_3000, 1'b1, 1'b1, 1'b0);
        step("wait1",     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_3004, 32'h0000_0000, 32'h0000_3004, 1'b0, 1'b1, 1'b1);
        step("wait2",     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_3004, 32'h0000_0000, 32'h0000_3004, 1'b0, 1'b1, 1'b1);
        step("wait_done", 1'b1, 32'h1111_0002, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_3008, 32'h1111_0002, 32'h0000_3004, 1'b1, 1'b1, 1'b0);
        step("stall_ret", 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0000_300C, 32'h0000_3008, 32'h1111_0002, 32'h0000_3004, 1'b1, 1'b0, 1'b0);
        step("hold_stl",  1'b1, 32'hBBBB_0000, 1'b1, 1'b0, 32'h0000_300C, 32'h0000_3008, 32'h1111_0002, 32'h0000_3004, 1'b1, 1'b0, 1'b0);
        step("hold_go",   1'b0, 32'hBBBB_0000, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_3008, 32'hAAAA_0001, 32'h0000_3008, 1'b1, 1'b1, 1'b1);
        step("flush",     1'b1, 32'hDEAD_0000, 1'b0, 1'b1, 32'h0000_3010, 32'h0000_3010, 32'h0000_0000, 32'h0000_3008, 1'b0, 1'b1, 1'b0);
        step("stl_flush", 1'b1, 32'hCAFE_0000, 1'b1, 1'b1, 32'h0000_3014, 32'h0000_3010, 32'h0000_0000, 32'h0000_3008, 1'b0, 1'b0, 1'b0);
        step("hold_fl",   1'b1, 32'h7777_0000, 1'b0, 1'b1, 32'h0000_3014, 32'h0000_3014, 32'h0000_0000, 32'h0000_3010, 1'b0, 1'b1, 1'b0);
        step("stl_wait",  1'b0, 32'h7777_0000, 1'b1, 1'b0, 32'h0000_3018, 32'h0000_3014, 32'h0000_0000, 32'h0000_3010, 1'b0, 1'b1, 1'b1);
        step("to_top",    1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_3014, 1'b1, 1'b1, 1'b0);
        step("wrap",      1'b1, 32'h8765_4321, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8765_4321, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        step("hold_rst",  1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h8765_4321, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        drain();

        // Between edges while in HOLD: reset must act without waiting for a clock.
        imem_ready = 1'b0;
        stall      = 1'b0;
        reset      = 1'b0;
        #1;
        chk_all("async_rst", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst",  1'b0, 32'h5555_0000, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1'b0, 1'b1, 1'b1);
        step("rst_fetch", 1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3004, 32'h9999_0000, 32'h0000_3000, 1'b1, 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, SHALL be the instruction word placed in IF/ID for a bubble.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 npc  input  32  next-PC value from the next-PC unit, valid in the cycle the fetch advances.
REQ-006 stall  input  1  hazard-unit stall; holds the PC and IF/ID.
REQ-007 flush  input  1  annul request for the instruction entering IF/ID, used for the delay slot of a not-taken likely branch.
REQ-008 pc  output  32  current fetch PC, fed back to the next-PC unit.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  read address; SHALL equal pc.
REQ-011 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 if_id_instr  output  32  IF/ID instruction register.
REQ-014 if_id_pc  output  32  IF/ID PC register.
REQ-015 if_id_valid  output  1  IF/ID holds a real, non-annulled instruction.
REQ-016 fetch_busy  output  1  high while a request is outstanding without imem_ready.

Function
REQ-017 The FSM SHALL have two states: REQ, where a request is issued, and HOLD, where the word was captured under stall.
REQ-018 In REQ the block SHALL assert imem_req; in HOLD it SHALL deassert imem_req.
REQ-019 fetch_busy SHALL equal (state==REQ && !imem_ready), combinationally.
REQ-020 The fetch advances in a cycle when (REQ && imem_ready && !stall) or (HOLD && !stall).
REQ-021 On advance, pc SHALL be loaded with npc, and IF/ID SHALL be loaded with {word, pc, valid=1}; word is imem_rdata in REQ and the skid buffer in HOLD.
REQ-022 On advance with flush=1, IF/ID SHALL instead load {NOP_WORD, pc, valid=0}, and pc SHALL still load npc.
REQ-023 In REQ, when imem_ready=1 and stall=1, the block SHALL capture imem_rdata into the skid buffer, keep pc and IF/ID, and enter HOLD.
REQ-024 In REQ, when imem_ready=0 and stall=0, IF/ID SHALL load a bubble {NOP_WORD, pc, 0}, pc SHALL be held, and the state SHALL stay REQ.
REQ-025 When stall=1, IF/ID and pc SHALL be held regardless of flush; stall takes precedence and flush is ignored.
REQ-026 In HOLD with stall=1, all state SHALL be held, and memory inputs SHALL be ignored.
REQ-027 After HOLD is left on advance, the state SHALL be REQ.
REQ-028 pc arithmetic SHALL be a full 32-bit load with no alignment check; a wrap from 32'hFFFF_FFFC to npc is a plain load.
REQ-029 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-030 While reset=0, asynchronously: pc=PC_RESET, state=REQ, if_id_instr=NOP_WORD, if_id_pc=PC_RESET, if_id_valid=0, skid buffer=0.
REQ-031 On the first clk edge after reset deasserts, the block SHALL be in REQ with imem_req=1 and imem_addr=PC_RESET.
REQ-032 Reset asserted mid-HOLD or mid-request SHALL discard the buffered word and the outstanding request.

Verification
REQ-033 Zero-wait fetch: imem_ready=1, rdata=32'h2408_0005, npc=32'h3004 -> next edge if_id_instr=32'h2408_0005, if_id_pc=32'h3000, valid=1, pc=32'h3004.
REQ-034 Wait states: imem_ready=0 for 2 cycles at pc=32'h3004 -> fetch_busy=1, two bubbles (valid=0, pc held), then the word on the third cycle.
REQ-035 Stall on return: ready=1, stall=1, rdata=32'hAAAA_0001 -> HOLD, imem_req=0, IF/ID unchanged; stall drops -> if_id_instr=32'hAAAA_0001, pc=npc.
REQ-036 Flush: advance with flush=1 at pc=32'h3008 -> if_id_instr=0, valid=0, if_id_pc=32'h3008, pc=npc; stall=1 with flush=1 -> no change.
REQ-037 Async reset: reset pulled low between edges in HOLD -> outputs reach reset values immediately, and pc=32'h3000 on release.
